// File: rtl/aes_pkg.sv
// Shared constants and FSM state type for the AES-128 inverse round controller.
// Provides: block/key widths, round count, round-key index width, FSM state enum.
package aes_pkg;

  localparam int unsigned AES128_BLK_W  = 128;
  localparam int unsigned AES_KEY_W     = 128;
  localparam int unsigned AES_NR        = 10;
  localparam int unsigned AES_KEY_IDX_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_ARK,
    S_ISS,
    S_IMC,
    S_DONE
  } inv_state_e;

endpackage

// File: rtl/aes_hs_wait.sv
// Generic hold-enable-until-done handshake with optional watchdog.
// Optional feature macro: AES_INV_WDOG_EN (enables the per-wait timeout counter).
// Ports:
//   clk, rst_n : clock, async active-low reset
//   enter      : pulse, the owning FSM enters this wait state on the next edge
//   done       : partner's done/ack; only honoured while en is high
//   en         : registered enable/request, high for the whole wait
//   fire       : en & done, the wait completes on this edge
//   timeout    : watchdog expired this cycle (constant 0 without the macro)
module aes_hs_wait #(
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enter,
  input  logic done,
  output logic en,
  output logic fire,
  output logic timeout
);

  logic en_q, en_d;

  assign en   = en_q;
  assign fire = en_q & done;

  always_comb begin
    en_d = en_q;
    if (enter)                en_d = 1'b1;
    else if (fire || timeout) en_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) en_q <= 1'b0;
    else        en_q <= en_d;
  end

`ifdef AES_INV_WDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter holds the number of completed wait cycles; expiry fires in the
  // WDOG_CYCLES-th waiting cycle if done has not arrived.
  assign timeout = en_q & ~done & (cnt_q == CNT_W'(WDOG_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (enter)     cnt_d = '0;
    else if (en_q) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  // No watchdog: waits are unbounded. The parameter is kept so the
  // instantiation is identical in both builds.
  assign timeout = 1'b0 & (WDOG_CYCLES == 0);
`endif

endmodule

// File: rtl/aes_inv_rounds_ctrl.sv
// AES-128 inverse-cipher round sequencer. Owns the state register, performs
// AddRoundKey as an inline XOR, fetches round keys NR..0 and drives the
// external inv_sub_shift and inv_mix_columns engines via enable/done handshakes.
// Optional feature macro: AES_INV_WDOG_EN (watchdog on KEY/ISS/IMC waits, sticky err).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   start, ct_in               : begin decryption (sampled in IDLE only), ciphertext
//   ready, busy                : idle indicator, operation-in-progress indicator
//   pt_out, pt_valid           : plaintext, one-cycle valid pulse
//   key_req, key_idx, key_ack, key_in : round-key fetch handshake
//   st_out                     : current state register, feeds both engines
//   iss_en, iss_done, iss_res  : InvShiftRows+InvSubBytes engine handshake
//   imc_en, imc_done, imc_res  : InvMixColumns engine handshake
//   err                        : sticky watchdog error
module aes_inv_rounds_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR          = AES_NR,
  parameter int unsigned KEY_IDX_W   = AES_KEY_IDX_W,
  parameter int unsigned WDOG_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [AES128_BLK_W-1:0] ct_in,
  output logic                    ready,
  output logic                    busy,
  output logic [AES128_BLK_W-1:0] pt_out,
  output logic                    pt_valid,
  output logic                    key_req,
  output logic [KEY_IDX_W-1:0]    key_idx,
  input  logic                    key_ack,
  input  logic [AES_KEY_W-1:0]    key_in,
  output logic [AES128_BLK_W-1:0] st_out,
  output logic                    iss_en,
  input  logic                    iss_done,
  input  logic [AES128_BLK_W-1:0] iss_res,
  output logic                    imc_en,
  input  logic                    imc_done,
  input  logic [AES128_BLK_W-1:0] imc_res,
  output logic                    err
);

  localparam logic [KEY_IDX_W-1:0] NR_IDX = KEY_IDX_W'(NR);

  inv_state_e               state_q, state_d;
  logic [KEY_IDX_W-1:0]     r_q, r_d;
  logic [AES128_BLK_W-1:0]  st_q, st_d;
  logic [AES_KEY_W-1:0]     rk_q, rk_d;
  logic [AES128_BLK_W-1:0]  pt_q, pt_d;
  logic                     ready_q, busy_q, pt_valid_q;
  logic                     ready_d, busy_d, pt_valid_d;

  logic key_fire, iss_fire, imc_fire;
  logic key_to, iss_to, imc_to, any_to;
  logic enter_key, enter_iss, enter_imc;

  assign any_to = key_to | iss_to | imc_to;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    st_d    = st_q;
    rk_d    = rk_q;
    pt_d    = pt_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        st_d    = ct_in;
        r_d     = NR_IDX;
        state_d = S_KEY;
      end
      S_KEY: if (key_fire) begin
        rk_d    = key_in;
        state_d = S_ARK;
      end
      S_ARK: begin
        st_d = st_q ^ rk_q;
        if (r_q == NR_IDX) begin
          r_d     = r_q - KEY_IDX_W'(1);
          state_d = S_ISS;
        end else if (r_q == '0) begin
          // Plaintext is captured here so pt_out is already valid while DONE
          // raises pt_valid.
          pt_d    = st_q ^ rk_q;
          state_d = S_DONE;
        end else begin
          state_d = S_IMC;
        end
      end
      S_ISS: if (iss_fire) begin
        st_d    = iss_res;
        state_d = S_KEY;
      end
      S_IMC: if (imc_fire) begin
        st_d    = imc_res;
        r_d     = r_q - KEY_IDX_W'(1);
        state_d = S_ISS;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (any_to) state_d = S_IDLE;

    ready_d    = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
    pt_valid_d = (state_d == S_DONE);
  end

  // Handshake enables are registered inside aes_hs_wait; they are loaded on
  // the edge that enters the matching wait state, so en is high exactly while
  // the FSM sits in that state.
  assign enter_key = (state_d == S_KEY) && (state_q != S_KEY);
  assign enter_iss = (state_d == S_ISS) && (state_q != S_ISS);
  assign enter_imc = (state_d == S_IMC) && (state_q != S_IMC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      r_q        <= NR_IDX;
      st_q       <= '0;
      rk_q       <= '0;
      pt_q       <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      pt_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      st_q       <= st_d;
      rk_q       <= rk_d;
      pt_q       <= pt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      pt_valid_q <= pt_valid_d;
    end
  end

`ifdef AES_INV_WDOG_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == S_IDLE && start) err_d = 1'b0;
    if (any_to)                     err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  aes_hs_wait #(.WDOG_CYCLES(WDOG_CYCLES)) u_key_wait (
    .clk(clk), .rst_n(rst_n), .enter(enter_key), .done(key_ack),
    .en(key_req), .fire(key_fire), .timeout(key_to)
  );

  aes_hs_wait #(.WDOG_CYCLES(WDOG_CYCLES)) u_iss_wait (
    .clk(clk), .rst_n(rst_n), .enter(enter_iss), .done(iss_done),
    .en(iss_en), .fire(iss_fire), .timeout(iss_to)
  );

  aes_hs_wait #(.WDOG_CYCLES(WDOG_CYCLES)) u_imc_wait (
    .clk(clk), .rst_n(rst_n), .enter(enter_imc), .done(imc_done),
    .en(imc_en), .fire(imc_fire), .timeout(imc_to)
  );

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign pt_out   = pt_q;
  assign pt_valid = pt_valid_q;
  assign key_idx  = r_q;
  assign st_out   = st_q;

endmodule

// File: doc/aes_inv_rounds_ctrl.md
Name: aes_inv_rounds_ctrl

Overview:
Round sequencer for AES-128 decryption (inverse cipher, FIPS-197 §5.3), the decrypt-side counterpart of the encrypt round controller. Owns the 128-bit state register and performs AddRoundKey internally as an XOR. Fetches round keys 10 down to 0 from the expanded-key store. Drives the external inv_sub_shift (InvShiftRows+InvSubBytes) and inv_mix_columns engines through level-enable/done handshakes.

Parameters:
NR, 10, number of rounds; key indices run NR..0
KEY_IDX_W, 4, width of round-key index
WDOG_CYCLES, 255, max wait cycles per handshake (used only with AES_INV_WDOG_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin decryption of ct_in; sampled only in IDLE
ct_in  in  128  ciphertext, latched on accepted start
ready  out  1  high in IDLE
busy  out  1  high from start acceptance until DONE inclusive
pt_out  out  128  plaintext; valid from pt_valid until next accepted start
pt_valid  out  1  one-cycle pulse in DONE
key_req  out  1  round-key request, held until key_ack
key_idx  out  4  requested round index
key_ack  in  1  key_in valid this cycle
key_in  in  128  round key
st_out  out  128  current state register, feeds both engines
iss_en  out  1  inv_sub_shift enable, held until iss_done
iss_done  in  1  inv_sub_shift result valid
iss_res  in  128  inv_sub_shift result
imc_en  out  1  inv_mix_columns enable, held until imc_done
imc_done  in  1  inv_mix_columns result valid
imc_res  in  128  inv_mix_columns result
err  out  1  sticky watchdog error (tied 0 without AES_INV_WDOG_EN)

Behaviour:
- Reset (async, rst_n=0): state IDLE; round counter r=NR; state reg, pt_out = 0; ready=1; busy, pt_valid, key_req, iss_en, imc_en, err = 0; key_idx=NR. The same applies on reset mid-operation; in-flight engine results are discarded.
- FSM states: IDLE, KEY, ARK, ISS, IMC, DONE.
- IDLE: on start=1, latch ct_in into state reg, set r=NR, go to KEY. start is ignored in all other states.
- KEY: key_req=1 and key_idx=r. On key_ack, latch key_in and go to ARK.
- ARK: state ^= latched key.
  - r==NR: decrement r, go to ISS.
  - r==0: go to DONE.
  - otherwise: go to IMC.
- ISS: iss_en=1. On iss_done, state = iss_res, go to KEY.
- IMC: imc_en=1. On imc_done, state = imc_res, decrement r, go to ISS.
- DONE: pt_out = state, pt_valid=1 for one cycle, go to IDLE.
- Resulting order: ARK(10); then for r=9..1: ISS, ARK(r), IMC; then ISS, ARK(0).
- Enables and key_req are registered and deassert on the cycle after the done/ack edge.
- Handshake rules:
  - done/ack is sampled only in its own wait state; a spurious done/ack in any other state is ignored.
  - done coincident with the enable's first cycle is legal.
- Latency with key_ack, iss_done and imc_done tied 1: pt_valid is high in the 42nd cycle after the start-sampling edge. Breakdown: 1 KEY + 1 ARK + 36 + 3 + 1 DONE.
- r never underflows; the ARK r==0 branch is checked before any decrement.

Optional Feature:
AES_INV_WDOG_EN:
- Defined: each wait state (KEY, ISS, IMC) runs a counter, cleared on state entry. If the counter reaches WDOG_CYCLES without ack/done, the block sets err=1 (sticky until reset or the next accepted start), drops all requests, and returns to IDLE without pt_valid.
- Undefined: no counter; waits are unbounded; err tied 0.

Decomposition:
- Package aes_pkg: FSM state enum, NR, state/key width constants, AES128_BLK_W=128.
- One natural sub-module: aes_hs_wait. It implements the generic hold-enable-until-done handshake plus the optional watchdog and is instantiated for KEY, ISS and IMC.
- The XOR for AddRoundKey stays inline.

Test Plan:
- FIPS-197 C.1: key 000102…0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a, behavioural engine/key models with 0-wait → pt_out 00112233445566778899aabbccddeeff, pt_valid at cycle 42.
- Same vector with random 0–7 cycle waits on key_ack/iss_done/imc_done → same pt_out; key_idx sequence 10,9,…,0; exactly 9 imc_en episodes.
- start pulsed while busy, and spurious iss_done during KEY → ignored; result unchanged.
- rst_n asserted during round 5 IMC → all outputs at reset values immediately; next start decrypts correctly.
- Two back-to-back starts (start high in the cycle ready returns) → two correct pt_valid pulses with distinct pt_out.
- With AES_INV_WDOG_EN and WDOG_CYCLES=16, iss_done held 0 → err=1 after 16 cycles, state IDLE, no pt_valid; the next start clears err.
